mcntl_noc_tx: RTL
=================

Name: mcntl_noc_tx

Overview:
- Manager-side transmit controller: the return path from the MWC toward the manager NoC port, complementing the inbound NoC-to-MWC path in mgr_cntl.
- Buffers flits from the MWC, enforces packet framing (SOM/MOM/EOM), and drives the NoC data-path interface.
- Handles delayed-ready flow control on both sides.
- Counts packets and framing errors for debug.

Parameters:
- FIFO_DEPTH, 8, flit buffer entries; power of two, ≥ 4.
- FIFO_AFULL, 4, minimum free entries required to keep mcntl__mwc__tx_ready asserted.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock
- reset_poweron  in  1  synchronous reset, active-low (0 = reset)
- mwc__mcntl__tx_valid  in  1  flit valid from MWC
- mwc__mcntl__tx_cntl  in  `COMMON_STD_INTF_CNTL_RANGE  SOM_EOM/SOM/MOM/EOM
- mwc__mcntl__tx_type  in  `MGR_NOC_CONT_NOC_PACKET_TYPE_RANGE  packet type
- mwc__mcntl__tx_ptype  in  `MGR_NOC_CONT_NOC_PAYLOAD_TYPE_RANGE  payload type
- mwc__mcntl__tx_data  in  `MGR_NOC_CONT_INTERNAL_DATA_RANGE  payload
- mwc__mcntl__tx_pvalid  in  1  payload valid
- mwc__mcntl__tx_mgrId  in  `MGR_MGR_ID_RANGE  destination manager
- mcntl__mwc__tx_ready  out  1  registered; MWC may send while high
- mcntl__noc__dp_valid/cntl/type/ptype/data/pvalid/mgrId  out  same widths  flit to NoC, all registered
- noc__mcntl__dp_ready  in  1  NoC ready
- sys__mgr__mgrId  in  `MGR_MGR_ID_RANGE  local id; loopback detection only
- mcntl__sts__pkt_cnt  out  16  packets sent, wraps
- mcntl__sts__err_cnt  out  ERR_CNT_W  framing errors, saturating
- mcntl__sts__loopback  out  1  pulse: SOM sent with mgrId == sys__mgr__mgrId

Behaviour:
Reset:
- All outputs are 0; FIFO is empty; FSM is in IDLE.
- Reset mid-packet discards all buffered flits. The NoC side sees valid drop with no EOM; the NoC resets with the manager.

Input side:
- A flit is written to the FIFO when mwc__mcntl__tx_valid = 1. No dependence on same-cycle ready.
- mcntl__mwc__tx_ready(t+1) = (free entries at t ≥ FIFO_AFULL).
- The MWC may issue up to 2 flits after ready falls.
- A write into a full FIFO is dropped, increments err_cnt, and flags a simulation assertion.

Output side:
- noc__mcntl__dp_ready is registered to ready_d1.
- A flit is popped only when FIFO is non-empty and ready_d1 = 1.
- Popped flits appear on the mcntl__noc__dp_* outputs the next cycle with valid = 1.
- Valid is 0 in every other cycle.
- FIFO-to-output latency is 2 cycles minimum (ready register + output register).
- Empty-to-output latency from MWC valid is 3 cycles.

FSM (evaluated on the head flit when a pop is allowed):
- IDLE, head SOM_EOM: forward; pkt_cnt++; stay in IDLE.
- IDLE, head SOM: forward; go to PKT.
- IDLE, head MOM/EOM: pop and discard (no output valid); err_cnt++; stay in IDLE.
- PKT, head MOM: forward.
- PKT, head EOM: forward; pkt_cnt++; go to IDLE.
- PKT, head SOM/SOM_EOM: forward with cntl rewritten to EOM; err_cnt++; pkt_cnt++; go to IDLE. The offending flit closes the open packet.
- type, ptype, data, pvalid and mgrId always pass through unmodified.
- mcntl__sts__loopback is a 1-cycle pulse coincident with the output SOM/SOM_EOM flit whose mgrId equals sys__mgr__mgrId.

Simultaneous events:
- Write and pop in the same cycle are both honoured; occupancy is unchanged.
- Write at full while a pop occurs is accepted (not an overflow).

Counters:
- pkt_cnt wraps 0xFFFF → 0.
- err_cnt saturates at 2^ERR_CNT_W − 1.
- An overflow and a framing error in the same cycle increment err_cnt by 2, subject to saturation.

Decomposition:
- Shared package / mgr_cntl.vh:
  - `MGR_CNTL_TX_FIFO_DEPTH, `MGR_CNTL_TX_AFULL
  - FSM state encodings `MGR_CNTL_TX_STATE_IDLE / _PKT (2-bit range)
  - flit bundle width `MGR_CNTL_TX_FLIT_RANGE (sum of cntl, type, ptype, data, pvalid, mgrId)
- The COMMON_STD_INTF_CNTL encodings are already in common.vh.
- Sub-module mcntl_tx_fifo: single-clock FIFO with a packed flit bundle and write, pop, empty, full and free-count ports. Instantiated once.

Test Plan:
- 3-flit packet SOM/MOM/EOM, mgrId=2, sys id=0, NoC ready=1 → NoC sees 3 consecutive valids; SOM appears 3 cycles after first MWC valid; pkt_cnt=1; err_cnt=0; no loopback.
- 20 back-to-back SOM_EOM flits, NoC ready held 0 → tx_ready falls once 4 flits are held; after ≤2 further flits, nothing is lost or overflowed; release ready → all buffered flits emerge in order; pkt_cnt = flits sent.
- Stray EOM while IDLE, then SOM_EOM data=0xA5 → EOM never appears on NoC; err_cnt=1; 0xA5 forwarded.
- SOM, MOM, then SOM (data=0x33) → third output flit has cntl=EOM, data=0x33; err_cnt=1; pkt_cnt=1.
- SOM_EOM with mgrId == sys__mgr__mgrId=5 → loopback pulse for exactly 1 cycle, aligned with NoC valid.
- Reset (reset_poweron=0) with 3 flits buffered mid-packet → after release, valid=0, tx_ready=1 within 1 cycle, counters are 0, and a new SOM_EOM passes normally.

Source files
------------

// File: rtl/mcntl_noc_tx_pkg.sv
// mcntl_noc_tx_pkg
//   Shared definitions for the manager-side transmit path:
//   - flit field widths and the packed flit bundle carried through the buffer
//   - framing control encodings (SOM_EOM / SOM / MOM / EOM)
//   - transmit FSM state encodings
//   - default buffer depth and almost-full threshold
package mcntl_noc_tx_pkg;

  localparam int CNTL_W  = 2;
  localparam int TYPE_W  = 3;
  localparam int PTYPE_W = 4;
  localparam int DATA_W  = 64;
  localparam int MGRID_W = 4;

  localparam int MGR_CNTL_TX_FIFO_DEPTH = 8;
  localparam int MGR_CNTL_TX_AFULL      = 4;

  typedef enum logic [CNTL_W-1:0] {
    CNTL_SOM_EOM = 2'd0,
    CNTL_SOM     = 2'd1,
    CNTL_MOM     = 2'd2,
    CNTL_EOM     = 2'd3
  } cntl_e;

  typedef enum logic [1:0] {
    TX_STATE_IDLE = 2'd0,
    TX_STATE_PKT  = 2'd1
  } tx_state_e;

  typedef struct packed {
    logic [CNTL_W-1:0]  cntl;
    logic [TYPE_W-1:0]  pkt_type;
    logic [PTYPE_W-1:0] pay_type;
    logic [DATA_W-1:0]  data;
    logic               pvalid;
    logic [MGRID_W-1:0] mgr_id;
  } tx_flit_t;

  localparam int MGR_CNTL_TX_FLIT_W = $bits(tx_flit_t);

  // True for the two encodings that open a packet.
  function automatic logic is_som(input logic [CNTL_W-1:0] c);
    return (c == CNTL_SOM) || (c == CNTL_SOM_EOM);
  endfunction

endpackage

// File: rtl/mcntl_tx_fifo.sv
// mcntl_tx_fifo
//   Single-clock flit buffer holding packed tx_flit_t bundles.
// Ports:
//   clk, reset_poweron  clock, synchronous active-low reset (empties buffer)
//   wr, wr_flit         write request and flit; dropped when full unless a
//                       pop happens in the same cycle
//   pop                 remove head entry (ignored when empty)
//   head                current head flit (valid while !empty)
//   empty, full         occupancy flags
//   free_cnt            number of free entries
module mcntl_tx_fifo
  import mcntl_noc_tx_pkg::*;
#(
  parameter int DEPTH = MGR_CNTL_TX_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset_poweron,
  input  logic                     wr,
  input  tx_flit_t                 wr_flit,
  input  logic                     pop,
  output tx_flit_t                 head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   free_cnt
);

  localparam int AW = $clog2(DEPTH);

  tx_flit_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            do_wr;
  logic            do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign free_cnt = (AW+1)'(DEPTH) - count;
  assign head     = mem[rd_ptr];

  // A write into a full buffer still lands when the head leaves in the
  // same cycle, since the freed slot is the one being overwritten last.
  assign do_pop = pop && !empty;
  assign do_wr  = wr && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!reset_poweron) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr)  wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_flit;
  end

endmodule

// File: rtl/mcntl_noc_tx.sv
// mcntl_noc_tx
//   Manager-side transmit controller: buffers flits from the MWC, repairs
//   packet framing and drives the manager NoC data-path port.
// Ports:
//   clk, reset_poweron            clock, synchronous active-low reset
//   mwc__mcntl__tx_*              flit from MWC (valid, cntl, type, ptype,
//                                 data, pvalid, mgrId)
//   mcntl__mwc__tx_ready          registered; MWC may send while high and
//                                 may issue up to 2 more flits after it falls
//   mcntl__noc__dp_*              registered flit to NoC
//   noc__mcntl__dp_ready          NoC ready (registered internally)
//   sys__mgr__mgrId               local manager id for loopback detection
//   mcntl__sts__pkt_cnt           packets sent, wrapping
//   mcntl__sts__err_cnt           framing/overflow errors, saturating
//   mcntl__sts__loopback          pulse with an outgoing SOM/SOM_EOM to self
module mcntl_noc_tx
  import mcntl_noc_tx_pkg::*;
#(
  parameter int FIFO_DEPTH = MGR_CNTL_TX_FIFO_DEPTH,
  parameter int FIFO_AFULL = MGR_CNTL_TX_AFULL,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset_poweron,
  input  logic                 mwc__mcntl__tx_valid,
  input  logic [CNTL_W-1:0]    mwc__mcntl__tx_cntl,
  input  logic [TYPE_W-1:0]    mwc__mcntl__tx_type,
  input  logic [PTYPE_W-1:0]   mwc__mcntl__tx_ptype,
  input  logic [DATA_W-1:0]    mwc__mcntl__tx_data,
  input  logic                 mwc__mcntl__tx_pvalid,
  input  logic [MGRID_W-1:0]   mwc__mcntl__tx_mgrId,
  output logic                 mcntl__mwc__tx_ready,
  output logic                 mcntl__noc__dp_valid,
  output logic [CNTL_W-1:0]    mcntl__noc__dp_cntl,
  output logic [TYPE_W-1:0]    mcntl__noc__dp_type,
  output logic [PTYPE_W-1:0]   mcntl__noc__dp_ptype,
  output logic [DATA_W-1:0]    mcntl__noc__dp_data,
  output logic                 mcntl__noc__dp_pvalid,
  output logic [MGRID_W-1:0]   mcntl__noc__dp_mgrId,
  input  logic                 noc__mcntl__dp_ready,
  input  logic [MGRID_W-1:0]   sys__mgr__mgrId,
  output logic [15:0]          mcntl__sts__pkt_cnt,
  output logic [ERR_CNT_W-1:0] mcntl__sts__err_cnt,
  output logic                 mcntl__sts__loopback
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ERR_CNT_W:0] ERR_MAX = {1'b0, {ERR_CNT_W{1'b1}}};

  logic               in_valid_q;
  tx_flit_t           in_flit_q;
  logic               ready_d1;
  tx_flit_t           head;
  logic               empty;
  logic               full;
  logic [CW-1:0]      free_cnt;
  logic               pop;
  logic               overflow;
  tx_state_e          state;
  tx_state_e          state_nxt;
  logic               fwd;
  logic               pkt_inc;
  logic               frm_err;
  logic [CNTL_W-1:0]  out_cntl;
  logic [1:0]         err_inc;
  logic [ERR_CNT_W:0] err_sum;

  // Input staging register: the MWC flit is captured unconditionally and
  // written into the buffer one cycle later, giving the 3-cycle
  // empty-to-output latency (stage, ready/pop, output register).
  always_ff @(posedge clk) begin
    if (!reset_poweron) begin
      in_valid_q <= 1'b0;
      in_flit_q  <= '0;
    end else begin
      in_valid_q <= mwc__mcntl__tx_valid;
      in_flit_q  <= '{cntl:     mwc__mcntl__tx_cntl,
                      pkt_type: mwc__mcntl__tx_type,
                      pay_type: mwc__mcntl__tx_ptype,
                      data:     mwc__mcntl__tx_data,
                      pvalid:   mwc__mcntl__tx_pvalid,
                      mgr_id:   mwc__mcntl__tx_mgrId};
    end
  end

  mcntl_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk           (clk),
    .reset_poweron (reset_poweron),
    .wr            (in_valid_q),
    .wr_flit       (in_flit_q),
    .pop           (pop),
    .head          (head),
    .empty         (empty),
    .full          (full),
    .free_cnt      (free_cnt)
  );

  assign pop      = !empty && ready_d1;
  assign overflow = in_valid_q && full && !pop;

  // The staged flit already owns a slot, so it is subtracted from the free
  // space before comparing; this keeps the 2-flit skid after ready falls
  // from overrunning the buffer.
  always_ff @(posedge clk) begin
    if (!reset_poweron) begin
      ready_d1             <= 1'b0;
      mcntl__mwc__tx_ready <= 1'b0;
    end else begin
      ready_d1             <= noc__mcntl__dp_ready;
      mcntl__mwc__tx_ready <= (free_cnt >= (CW'(FIFO_AFULL) + CW'(in_valid_q)));
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_poweron) state <= TX_STATE_IDLE;
    else                state <= state_nxt;
  end

  // Framing FSM, evaluated on the head flit whenever it is popped. Stray
  // MOM/EOM in IDLE are discarded; a new SOM inside a packet is rewritten
  // to EOM so that it closes the open packet.
  always_comb begin
    state_nxt = state;
    fwd       = 1'b0;
    pkt_inc   = 1'b0;
    frm_err   = 1'b0;
    out_cntl  = head.cntl;
    if (pop) begin
      case (state)
        TX_STATE_IDLE: begin
          case (head.cntl)
            CNTL_SOM_EOM: begin
              fwd     = 1'b1;
              pkt_inc = 1'b1;
            end
            CNTL_SOM: begin
              fwd       = 1'b1;
              state_nxt = TX_STATE_PKT;
            end
            default: frm_err = 1'b1;
          endcase
        end
        TX_STATE_PKT: begin
          case (head.cntl)
            CNTL_MOM: fwd = 1'b1;
            CNTL_EOM: begin
              fwd       = 1'b1;
              pkt_inc   = 1'b1;
              state_nxt = TX_STATE_IDLE;
            end
            default: begin
              fwd       = 1'b1;
              out_cntl  = CNTL_EOM;
              frm_err   = 1'b1;
              pkt_inc   = 1'b1;
              state_nxt = TX_STATE_IDLE;
            end
          endcase
        end
        default: state_nxt = TX_STATE_IDLE;
      endcase
    end
  end

  // NoC output register. Payload fields only load on a forwarded flit.
  always_ff @(posedge clk) begin
    if (!reset_poweron) begin
      mcntl__noc__dp_valid  <= 1'b0;
      mcntl__noc__dp_cntl   <= '0;
      mcntl__noc__dp_type   <= '0;
      mcntl__noc__dp_ptype  <= '0;
      mcntl__noc__dp_data   <= '0;
      mcntl__noc__dp_pvalid <= 1'b0;
      mcntl__noc__dp_mgrId  <= '0;
      mcntl__sts__loopback  <= 1'b0;
    end else begin
      mcntl__noc__dp_valid <= fwd;
      mcntl__sts__loopback <= fwd && is_som(out_cntl) &&
                              (head.mgr_id == sys__mgr__mgrId);
      if (fwd) begin
        mcntl__noc__dp_cntl   <= out_cntl;
        mcntl__noc__dp_type   <= head.pkt_type;
        mcntl__noc__dp_ptype  <= head.pay_type;
        mcntl__noc__dp_data   <= head.data;
        mcntl__noc__dp_pvalid <= head.pvalid;
        mcntl__noc__dp_mgrId  <= head.mgr_id;
      end
    end
  end

  // Overflow and framing error can land together and add 2 at once.
  assign err_inc = {1'b0, overflow} + {1'b0, frm_err};
  assign err_sum = {1'b0, mcntl__sts__err_cnt} + (ERR_CNT_W+1)'(err_inc);

  // Status counters: packet count wraps, error count saturates.
  always_ff @(posedge clk) begin
    if (!reset_poweron) begin
      mcntl__sts__pkt_cnt <= '0;
      mcntl__sts__err_cnt <= '0;
    end else begin
      mcntl__sts__pkt_cnt <= mcntl__sts__pkt_cnt + 16'(pkt_inc);
      mcntl__sts__err_cnt <= (err_sum > ERR_MAX) ? ERR_MAX[ERR_CNT_W-1:0]
                                                 : err_sum[ERR_CNT_W-1:0];
    end
  end

  // A write landing on a full buffer means the MWC ignored tx_ready.
  a_no_overflow : assert property (@(posedge clk) disable iff (!reset_poweron) !overflow);

endmodule
